// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl: sequences the var_len_shift_ram line buffer, gating CE by the pixel stream and flagging valid KxK windows.
// Optional stride-2 window decimation is built in when LB_CTRL_STRIDE2_EN is defined.
module line_buffer_ctrl #(
  parameter int KERNEL_SIZE = 5,
  parameter int DIM_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DIM_WIDTH-1:0] cfg_fm_width,
  input  logic [DIM_WIDTH-1:0] cfg_fm_height,
  input  logic [2:0]           cfg_kernel_size,
  input  logic                 cfg_lb_mod,
`ifdef LB_CTRL_STRIDE2_EN
  input  logic                 cfg_stride2,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 out_ready,
  output logic                 lb_enable,
  output logic                 lb_mod,
  output logic [2:0]           lb_kernel_size,
  output logic [7:0]           lb_shift_depth,
  output logic                 win_valid,
  output logic [DIM_WIDTH-1:0] win_row,
  output logic [DIM_WIDTH-1:0] win_col,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state, nxt;
  logic [DIM_WIDTH-1:0] fm_width, fm_height, row, col, km1, dr, dc, sd;
  logic [DIM_WIDTH:0] cfg_w_dec, w_dec, cfg_k_ext;
  logic stride2, cfg_bad, accept, last_col, last_row, win_hit;
  // A width field of zero encodes the full 2^DIM_WIDTH columns
  assign cfg_w_dec = (cfg_fm_width == '0) ? {1'b1, {DIM_WIDTH{1'b0}}} : {1'b0, cfg_fm_width};
  assign w_dec = (fm_width == '0) ? {1'b1, {DIM_WIDTH{1'b0}}} : {1'b0, fm_width};
  assign cfg_k_ext = (DIM_WIDTH+1)'(cfg_kernel_size);
  assign cfg_bad = !(cfg_kernel_size == 3'd3 || cfg_kernel_size == 3'd5) || int'(cfg_kernel_size) > KERNEL_SIZE ||
                   cfg_w_dec < cfg_k_ext || {1'b0, cfg_fm_height} < cfg_k_ext;
  assign sd = cfg_fm_width - DIM_WIDTH'(2);
  assign km1 = DIM_WIDTH'(lb_kernel_size - 3'd1);
  assign last_col = {1'b0, col} == w_dec - (DIM_WIDTH+1)'(1);
  assign last_row = row == fm_height - DIM_WIDTH'(1);
  assign dr = row - km1;
  assign dc = col - km1;
  assign win_hit = accept && row >= km1 && col >= km1 && (!stride2 || !(dr[0] | dc[0]));
`ifndef LB_CTRL_STRIDE2_EN
  assign stride2 = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state == IDLE ? ((start && !cfg_bad) ? RUN : IDLE) :
          state == RUN  ? ((accept && last_col && last_row) ? FLUSH : RUN) : IDLE;
  end
  always_comb begin
    in_ready = state == RUN && out_ready;
    accept = in_ready && in_valid;
    lb_enable = accept;
    busy = state == RUN;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fm_width <= '0;
      fm_height <= '0;
      lb_kernel_size <= '0;
      lb_mod <= 1'b0;
      lb_shift_depth <= '0;
`ifdef LB_CTRL_STRIDE2_EN
      stride2 <= 1'b0;
`endif
      row <= '0;
      col <= '0;
      win_valid <= 1'b0;
      win_row <= '0;
      win_col <= '0;
      done <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      win_valid <= win_hit;
      done <= state == FLUSH;
      cfg_err <= state == IDLE && start && cfg_bad;
      if (state == IDLE && start) begin
        fm_width <= cfg_fm_width;
        fm_height <= cfg_fm_height;
        lb_kernel_size <= cfg_kernel_size;
        lb_mod <= cfg_lb_mod;
        lb_shift_depth <= 8'(sd);
`ifdef LB_CTRL_STRIDE2_EN
        stride2 <= cfg_stride2;
`endif
        row <= '0;
        col <= '0;
      end else if (accept) begin
        col <= last_col ? '0 : col + DIM_WIDTH'(1);
        if (last_col) row <= row + DIM_WIDTH'(1);
      end
      if (win_hit) begin
        win_row <= stride2 ? dr >> 1 : dr;
        win_col <= stride2 ? dc >> 1 : dc;
      end
    end
  end
endmodule

// File: doc/line_buffer_ctrl.md
Name: line_buffer_ctrl

Overview:
- Sequencer for the line buffer datapath (var_len_shift_ram cascade) in the conv front end.
- Latches per-layer config on start and programs the line buffer's kernel size, mode and shift-RAM depth.
- Gates the line buffer CE with an upstream valid/ready stream and downstream backpressure.
- Tracks row/column position and flags the cycles where line buffer output holds a complete KxK window column set.

Parameters:
- KERNEL_SIZE, 5, max kernel supported (3 or 5 selectable at run time)
- DIM_WIDTH, 8, width of feature-map width/height fields and counters

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- start  in  1  one-cycle pulse; latches cfg_* when IDLE
- cfg_fm_width  in  DIM_WIDTH  columns per row; legal range KERNEL..256, where 256 is encoded as 0
- cfg_fm_height  in  DIM_WIDTH  rows per frame; legal range K..255
- cfg_kernel_size  in  3  3 or 5
- cfg_lb_mod  in  1  line buffer mode passed through
- in_valid  in  1  upstream pixel column valid
- in_ready  out  1  controller accepts pixel this cycle
- out_ready  in  1  downstream window consumer can take a window
- lb_enable  out  1  CE to line buffer
- lb_mod  out  1  latched cfg_lb_mod
- lb_kernel_size  out  3  latched cfg_kernel_size
- lb_shift_depth  out  8  shift-RAM depth code
- win_valid  out  1  line buffer data_out is a valid window column
- win_row  out  DIM_WIDTH  output row index of the window
- win_col  out  DIM_WIDTH  output column index of the window
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at frame end
- cfg_err  out  1  one-cycle pulse on illegal config

Behaviour:
- Reset values: all outputs 0. FSM=IDLE. Counters 0.
- FSM states: IDLE, RUN, FLUSH.
- IDLE:
  - On start, latch cfg.
  - If cfg_kernel_size is not 3 or 5, or fm_width (decoded) < K, or fm_height < K: pulse cfg_err next cycle and stay IDLE.
  - Otherwise go RUN, clear col/row.
- RUN:
  - in_ready = out_ready.
  - accept = in_valid & in_ready.
  - lb_enable = accept (combinational). The line buffer never shifts without an accept.
  - On accept, col increments. At col == fm_width-1, col wraps to 0 and row increments.
- Window qualification:
  - Accept at (row>=K-1, col>=K-1) registers win_valid=1 for exactly the next cycle.
  - Same cycle: win_row=row-(K-1), win_col=col-(K-1).
  - This aligns win_valid with the line buffer Q update (one-cycle CE-to-Q).
  - Otherwise win_valid=0 next cycle.
- lb_shift_depth = fm_width-2, 8-bit wrap (the SRL delay is A+1, so row delay = fm_width-1 plus the output register). Driven from latched cfg, stable throughout RUN.
- Last-pixel accept (row==fm_height-1, col==fm_width-1) goes to FLUSH.
- FLUSH:
  - in_ready=0, lb_enable=0.
  - After one cycle (the last win_valid is visible), pulse done and go IDLE.
- start while RUN/FLUSH is ignored, with no cfg change.
- Simultaneous accept and out_ready drop cannot happen: in_ready depends on out_ready in the same cycle.
- rst_n low mid-frame forces IDLE immediately and clears outputs/counters. Line buffer contents are stale; the next frame re-primes K-1 rows before win_valid.
- Windows per frame = (fm_height-K+1)*(fm_width-K+1).

Optional Feature:
- Macro LB_CTRL_STRIDE2_EN.
- When defined:
  - Adds input cfg_stride2 (1 bit), latched on start.
  - When latched high, win_valid asserts only where (row-(K-1)) and (col-(K-1)) are both even.
  - win_row/win_col report the halved indices.
  - Accept and lb_enable behaviour are unchanged, so every pixel is still shifted in.
- When undefined: no port, stride 1 only. Logic is identical to cfg_stride2=0.

Test Plan:
- K=3, fm 8x6, in_valid and out_ready held 1: 48 accepts; 24 win_valid pulses; first at the cycle after accept (2,2) with win_row=0, win_col=0; done 2 cycles after the last accept; lb_shift_depth=6.
- K=5, fm 12x7, random in_valid and out_ready: 24 windows in raster order, no duplicate or missing (row,col); lb_enable never high when in_valid=0 or out_ready=0.
- Config errors: cfg_kernel_size=4 -> cfg_err pulse, busy stays 0. fm_width=4 with K=5 -> cfg_err pulse, busy stays 0.
- start pulsed mid-frame with different cfg: ignored; lb_kernel_size and lb_shift_depth unchanged until done.
- rst_n asserted after 20 accepts of a 10x10 K=3 frame: outputs 0, FSM IDLE. Restart yields a full 64-window frame.
- With LB_CTRL_STRIDE2_EN, cfg_stride2=1, K=3, fm 9x9: 16 windows, win_row/win_col 0..3, 81 lb_enable cycles.
